mips_multicycle_ctrl: RTL and testbench
=======================================

// Module: mips_multicycle_ctrl
// PURPOSE
//  Moore FSM sequencing the multicycle MIPS datapath: IR/PC loads, memory access, register write-back, ALU mux selects and ALU op.
//  Sits beside the datapath; takes Op/Funct from IR and Zero from the ALU; drives every datapath enable/select and the 4-bit ALUControl.
// PARAMETERS
//  MD_CYCLES  4  cycles ALUControl is held on mul/div before write-back (MULDIV_EN only); legal 1..15
// PORTS
//  clk         in   1  rising-edge clock; single clock domain
//  reset       in   1  synchronous, active-high reset
//  Op          in   6  IR[31:26]
//  Funct       in   6  IR[5:0]
//  Zero        in   1  ALU compare flag (ALU codes 10/11)
//  IorD        out  1  mem addr: 0=PC, 1=ALUOut
//  MemWrite    out  1  data memory write strobe
//  IRWrite     out  1  instruction register load
//  RegDst      out  1  write reg: 0=rt, 1=rd
//  MemtoReg    out  1  write data: 0=ALUOut, 1=MDR
//  RegWrite    out  1  register file write
//  ALUSrcA     out  2  0=PC, 1=A, 2=zero-ext shamt
//  ALUSrcB     out  2  0=B, 1=const 4, 2=SignImm, 3=SignImm<<2
//  ALUControl  out  4  0 add,1 and,2 nor,3 or,4 slt,5 sll,6 srl,7 sub,8 div,9 mul,10 eq,11 ne,12 passB,14 lui
//  PCSrc       out  2  0=ALUResult, 1=ALUOut, 2=jump target
//  PCWrite     out  1  PC load (already qualified by Zero in BRANCH)
//  IllegalOp   out  1  one-cycle pulse in DECODE for unsupported Op/Funct
// BEHAVIOUR
//  - reset high: state<=FETCH next edge; while reset high all outputs forced 0. First cycle after release = FETCH.
//  - Outputs are pure functions of state (+Zero in BRANCH, Op/Funct in DECODE/EXEC); unlisted outputs 0 in each state.
//  - FETCH: IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=1, ALUControl=0, PCSrc=0, PCWrite=1 -> DECODE.
//  - DECODE: ALUSrcA=0, ALUSrcB=3, ALUControl=0 (branch target to ALUOut). Next by Op:
//     0x23/0x2B->MEMADR; 0x00->RTYPE_EX; 0x04/0x05->BRANCH; 0x08->ADDI_EX; 0x0C/0x0D/0x0F->LOGI_EX; 0x02->JUMP; else IllegalOp=1 ->FETCH.
//  - MEMADR: A+SignImm (SrcA=1,SrcB=2,ctl 0) -> MEMRD (lw) / MEMWR (sw).
//  - MEMRD: IorD=1 -> MEMWB. MEMWB: RegDst=0, MemtoReg=1, RegWrite=1 -> FETCH. MEMWR: IorD=1, MemWrite=1 -> FETCH.
//  - RTYPE_EX: SrcB=0; SrcA=2 for sll(0x00)/srl(0x02) else 1; ctl via Funct: 20 add,22 sub,24 and,25 or,27 nor,2A slt,00 sll,02 srl -> ALU_WB.
//    Unsupported Funct: IllegalOp pulses in DECODE, FSM returns to FETCH, no write.
//  - ALU_WB: RegDst=1, MemtoReg=0, RegWrite=1 -> FETCH. IMM_WB: RegDst=0, RegWrite=1 -> FETCH.
//  - ADDI_EX: SrcA=1,SrcB=2,ctl 0 -> IMM_WB. LOGI_EX: SrcA=1,SrcB=2, ctl andi=1, ori=3, lui=14 -> IMM_WB.
//  - BRANCH: SrcA=1,SrcB=0, ctl 10 (beq) / 11 (bne), PCSrc=1, PCWrite=Zero -> FETCH.
//  - JUMP: PCSrc=2, PCWrite=1 -> FETCH.
//  - Latency (cycles incl. FETCH): lw 5; sw, R-type, addi, logic-imm 4; beq/bne, j 3; illegal 2.
//  - Reset mid-instruction aborts it: no RegWrite/MemWrite/PCWrite in the cycle reset is sampled high.
// CONFIGURATION
//  MULDIV_EN defined: Funct 0x18 (mul, ctl 9) and 0x1A (div, ctl 8) legal; RTYPE_EX -> MD_WAIT; 4-bit counter
//   loads MD_CYCLES-1, holds ctl/selects, decrements to 0 -> ALU_WB. mul/div latency = 4 + MD_CYCLES.
//  MULDIV_EN undefined: 0x18/0x1A illegal (IllegalOp, back to FETCH); no counter, no MD_WAIT state.
// STRUCTURE
//  Package mips_ctrl_pkg: state_t enum, alu_ctl_t codes 0..14, OP_*/FUNCT_* localparams, ALUSrcA/B and PCSrc encodings.
//  Sub-module mips_alu_decoder: combinational Op/Funct -> ALUControl + funct-legal flag; instantiated once.
// TESTING
//  1 reset held 3 cycles, release -> all outputs 0 during reset; cycle 1 IRWrite=1,PCWrite=1,ALUSrcB=1.
//  2 Op=0x23 -> MemWrite never; MEMRD IorD=1; cycle 5 RegWrite=1,MemtoReg=1,RegDst=0; FETCH on cycle 6.
//  3 Op=0,Funct=0x00 (sll) -> cycle 3 ALUSrcA=2,ALUControl=5; cycle 4 RegWrite=1,RegDst=1.
//  4 Op=0x04 Zero=1 -> cycle 3 ALUControl=10,PCSrc=1,PCWrite=1; Zero=0 -> PCWrite=0; Op=0x05 -> ALUControl=11.
//  5 Op=0x3F -> IllegalOp=1 in cycle 2 only, next cycle FETCH, no writes; Funct=0x18 w/o MULDIV_EN same.
//  6 MULDIV_EN, MD_CYCLES=4, Funct=0x1A -> ALUControl=8 held 4 cycles, RegWrite on cycle 8; reset in MD_WAIT -> FETCH, no RegWrite.

Source files
------------

// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS controller.
// MULDIV_EN adds the mul/div funct codes and the MD_WAIT state.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_RTYPE_EX,
    S_ALU_WB,
    S_IMM_WB,
    S_ADDI_EX,
    S_LOGI_EX,
    S_BRANCH,
`ifdef MULDIV_EN
    S_MD_WAIT,
`endif
    S_JUMP
  } state_t;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_AND   = 4'd1,
    ALU_NOR   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_SLT   = 4'd4,
    ALU_SLL   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SUB   = 4'd7,
    ALU_DIV   = 4'd8,
    ALU_MUL   = 4'd9,
    ALU_EQ    = 4'd10,
    ALU_NE    = 4'd11,
    ALU_PASSB = 4'd12,
    ALU_LUI   = 4'd14
  } alu_ctl_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FUNCT_SLL = 6'h00;
  localparam logic [5:0] FUNCT_SRL = 6'h02;
  localparam logic [5:0] FUNCT_MUL = 6'h18;
  localparam logic [5:0] FUNCT_DIV = 6'h1A;
  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_NOR = 6'h27;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_A     = 2'd1;
  localparam logic [1:0] SRCA_SHAMT = 2'd2;

  localparam logic [1:0] SRCB_B      = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  typedef struct packed {
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_ctl;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       illegal_op;
  } ctrl_out_t;

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Controller <-> datapath bundle. Master = controller, slave = datapath.
// dbg_state mirrors the FSM state register for observation.
interface mips_multicycle_ctrl_if;
  import mips_ctrl_pkg::*;

  logic [5:0] Op;
  logic [5:0] Funct;
  logic       Zero;
  logic       IorD;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [3:0] ALUControl;
  logic [1:0] PCSrc;
  logic       PCWrite;
  logic       IllegalOp;
  state_t     dbg_state;

  modport master (
    input  Op, Funct, Zero,
    output IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUControl, PCSrc, PCWrite, IllegalOp, dbg_state
  );

  modport slave (
    output Op, Funct, Zero,
    input  IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUControl, PCSrc, PCWrite, IllegalOp, dbg_state
  );
endinterface

// File: rtl/mips_multicycle_ctrl_alu_decoder.sv
// Combinational Op/Funct -> ALUControl, plus a flag saying the R-type Funct is supported.
// MULDIV_EN makes mul (0x18) and div (0x1A) legal.
module mips_alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] i_op,
  input  logic [5:0] i_funct,
  output alu_ctl_t   o_alu_ctl,
  output logic       o_funct_legal
);

  always_comb begin
    o_alu_ctl     = ALU_ADD;
    o_funct_legal = 1'b0;
    case (i_op)
      OP_RTYPE: begin
        o_funct_legal = 1'b1;
        case (i_funct)
          FUNCT_ADD: o_alu_ctl = ALU_ADD;
          FUNCT_SUB: o_alu_ctl = ALU_SUB;
          FUNCT_AND: o_alu_ctl = ALU_AND;
          FUNCT_OR:  o_alu_ctl = ALU_OR;
          FUNCT_NOR: o_alu_ctl = ALU_NOR;
          FUNCT_SLT: o_alu_ctl = ALU_SLT;
          FUNCT_SLL: o_alu_ctl = ALU_SLL;
          FUNCT_SRL: o_alu_ctl = ALU_SRL;
`ifdef MULDIV_EN
          FUNCT_MUL: o_alu_ctl = ALU_MUL;
          FUNCT_DIV: o_alu_ctl = ALU_DIV;
`endif
          default:   o_funct_legal = 1'b0;
        endcase
      end
      OP_BEQ:  o_alu_ctl = ALU_EQ;
      OP_BNE:  o_alu_ctl = ALU_NE;
      OP_ANDI: o_alu_ctl = ALU_AND;
      OP_ORI:  o_alu_ctl = ALU_OR;
      OP_LUI:  o_alu_ctl = ALU_LUI;
      default: o_alu_ctl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Moore FSM sequencing the multicycle MIPS datapath.
// MULDIV_EN adds mul/div with an MD_CYCLES-long hold in MD_WAIT.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned MD_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  mips_multicycle_ctrl_if.master bus
);

  if (MD_CYCLES < 1 || MD_CYCLES > 15) begin : g_md_cycles_range
    $error("MD_CYCLES must be in 1..15");
  end

  state_t    r_state;
  state_t    w_next;
  ctrl_out_t w_out;
  alu_ctl_t  w_alu_ctl;
  logic      w_funct_legal;
  logic      w_is_shift;

  mips_alu_decoder u_alu_dec (
    .i_op          (bus.Op),
    .i_funct       (bus.Funct),
    .o_alu_ctl     (w_alu_ctl),
    .o_funct_legal (w_funct_legal)
  );

  assign w_is_shift = (bus.Funct == FUNCT_SLL) || (bus.Funct == FUNCT_SRL);

`ifdef MULDIV_EN
  localparam logic [3:0] MD_LOAD = 4'(MD_CYCLES - 1);
  logic [3:0] r_md_cnt;
  logic       w_is_muldiv;

  assign w_is_muldiv = (bus.Funct == FUNCT_MUL) || (bus.Funct == FUNCT_DIV);

  always_ff @(posedge clk) begin
    if (reset)
      r_md_cnt <= '0;
    else if (r_state == S_RTYPE_EX)
      r_md_cnt <= MD_LOAD;
    else if (r_state == S_MD_WAIT && r_md_cnt != '0)
      r_md_cnt <= r_md_cnt - 4'd1;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_out  = '0;
    w_next = S_FETCH;
    case (r_state)
      S_FETCH: begin
        w_out.ir_write  = 1'b1;
        w_out.alu_src_b = SRCB_FOUR;
        w_out.pc_write  = 1'b1;
        w_next          = S_DECODE;
      end
      S_DECODE: begin
        w_out.alu_src_b = SRCB_IMM_SH;
        case (bus.Op)
          OP_LW, OP_SW:             w_next = S_MEMADR;
          OP_BEQ, OP_BNE:           w_next = S_BRANCH;
          OP_ADDI:                  w_next = S_ADDI_EX;
          OP_ANDI, OP_ORI, OP_LUI:  w_next = S_LOGI_EX;
          OP_J:                     w_next = S_JUMP;
          OP_RTYPE: begin
            if (w_funct_legal) w_next = S_RTYPE_EX;
            else               w_out.illegal_op = 1'b1;
          end
          default:                  w_out.illegal_op = 1'b1;
        endcase
      end
      S_MEMADR: begin
        w_out.alu_src_a = SRCA_A;
        w_out.alu_src_b = SRCB_IMM;
        w_next          = (bus.Op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        w_out.iord = 1'b1;
        w_next     = S_MEMWB;
      end
      S_MEMWB: begin
        w_out.mem_to_reg = 1'b1;
        w_out.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        w_out.iord      = 1'b1;
        w_out.mem_write = 1'b1;
      end
      S_RTYPE_EX: begin
        w_out.alu_src_a = w_is_shift ? SRCA_SHAMT : SRCA_A;
        w_out.alu_src_b = SRCB_B;
        w_out.alu_ctl   = w_alu_ctl;
        w_next          = S_ALU_WB;
`ifdef MULDIV_EN
        if (w_is_muldiv) w_next = S_MD_WAIT;
`endif
      end
`ifdef MULDIV_EN
      S_MD_WAIT: begin
        w_out.alu_src_a = SRCA_A;
        w_out.alu_src_b = SRCB_B;
        w_out.alu_ctl   = w_alu_ctl;
        w_next          = (r_md_cnt == '0) ? S_ALU_WB : S_MD_WAIT;
      end
`endif
      S_ALU_WB: begin
        w_out.reg_dst   = 1'b1;
        w_out.reg_write = 1'b1;
      end
      S_IMM_WB: w_out.reg_write = 1'b1;
      S_ADDI_EX, S_LOGI_EX: begin
        w_out.alu_src_a = SRCA_A;
        w_out.alu_src_b = SRCB_IMM;
        w_out.alu_ctl   = (r_state == S_LOGI_EX) ? w_alu_ctl : ALU_ADD;
        w_next          = S_IMM_WB;
      end
      S_BRANCH: begin
        w_out.alu_src_a = SRCA_A;
        w_out.alu_src_b = SRCB_B;
        w_out.alu_ctl   = w_alu_ctl;
        w_out.pc_src    = PCSRC_ALUOUT;
        w_out.pc_write  = bus.Zero;
      end
      S_JUMP: begin
        w_out.pc_src   = PCSRC_JUMP;
        w_out.pc_write = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
    // Reset aborts the current instruction: nothing may be written this cycle.
    if (reset) w_out = '0;
  end

  assign bus.IorD       = w_out.iord;
  assign bus.MemWrite   = w_out.mem_write;
  assign bus.IRWrite    = w_out.ir_write;
  assign bus.RegDst     = w_out.reg_dst;
  assign bus.MemtoReg   = w_out.mem_to_reg;
  assign bus.RegWrite   = w_out.reg_write;
  assign bus.ALUSrcA    = w_out.alu_src_a;
  assign bus.ALUSrcB    = w_out.alu_src_b;
  assign bus.ALUControl = w_out.alu_ctl;
  assign bus.PCSrc      = w_out.pc_src;
  assign bus.PCWrite    = w_out.pc_write;
  assign bus.IllegalOp  = w_out.illegal_op;
  assign bus.dbg_state  = r_state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl; the mul/div steps are built only with MULDIV_EN.
// Outputs are packed into one vector and compared to hand-built per-cycle expectations.
module tb_mips_multicycle_ctrl;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  mips_multicycle_ctrl_if bus ();

  mips_multicycle_ctrl #(.MD_CYCLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {IorD,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,SrcA,SrcB,ALUControl,PCSrc,PCWrite,IllegalOp}
  function automatic logic [17:0] ov(input bit iord, input bit mw, input bit irw, input bit rd,
                                     input bit m2r, input bit rw, input int sa, input int sb,
                                     input int ctl, input int ps, input bit pw, input bit ill);
    logic [1:0] a;
    logic [1:0] b;
    logic [3:0] c;
    logic [1:0] p;
    a = 2'(sa);
    b = 2'(sb);
    c = 4'(ctl);
    p = 2'(ps);
    return {iord, mw, irw, rd, m2r, rw, a, b, c, p, pw, ill};
  endfunction

  function automatic logic [17:0] obs();
    return {bus.IorD, bus.MemWrite, bus.IRWrite, bus.RegDst, bus.MemtoReg, bus.RegWrite,
            bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl, bus.PCSrc, bus.PCWrite, bus.IllegalOp};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [17:0] exp);
    logic [17:0] o;
    o = obs();
    n_checks++;
    assert (o === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%05h expected=%05h", tag, o, exp);
    end
  endtask

  logic [17:0] e_zero, e_fetch, e_decode;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    e_zero   = ov(0,0,0,0,0,0, 0,0, 0,0,0,0);
    e_fetch  = ov(0,0,1,0,0,0, 0,1, 0,0,1,0);
    e_decode = ov(0,0,0,0,0,0, 0,3, 0,0,0,0);

    reset     = 1'b1;
    bus.Op    = 6'h23;
    bus.Funct = 6'h00;
    bus.Zero  = 1'b0;
    #1;
    chk("reset_t0", e_zero);
    step(); chk("reset_c1", e_zero);
    step(); chk("reset_c2", e_zero);
    step(); chk("reset_c3", e_zero);
    reset = 1'b0;
    #1;
    chk("lw_fetch", e_fetch);

    // lw: 5 cycles
    step(); chk("lw_decode", e_decode);
    step(); chk("lw_memadr", ov(0,0,0,0,0,0, 1,2, 0,0,0,0));
    step(); chk("lw_memrd",  ov(1,0,0,0,0,0, 0,0, 0,0,0,0));
    step(); chk("lw_memwb",  ov(0,0,0,0,1,1, 0,0, 0,0,0,0));
    step(); chk("lw_next_fetch", e_fetch);

    // sw
    bus.Op = 6'h2B;
    step(); chk("sw_decode", e_decode);
    step(); chk("sw_memadr", ov(0,0,0,0,0,0, 1,2, 0,0,0,0));
    step(); chk("sw_memwr",  ov(1,1,0,0,0,0, 0,0, 0,0,0,0));
    step(); chk("sw_next_fetch", e_fetch);

    // sll
    bus.Op = 6'h00; bus.Funct = 6'h00;
    step(); chk("sll_decode", e_decode);
    step(); chk("sll_ex", ov(0,0,0,0,0,0, 2,0, 5,0,0,0));
    step(); chk("sll_wb", ov(0,0,0,1,0,1, 0,0, 0,0,0,0));
    step(); chk("sll_next_fetch", e_fetch);

    // sub
    bus.Funct = 6'h22;
    step(); chk("sub_decode", e_decode);
    step(); chk("sub_ex", ov(0,0,0,0,0,0, 1,0, 7,0,0,0));
    step(); chk("sub_wb", ov(0,0,0,1,0,1, 0,0, 0,0,0,0));
    step(); chk("sub_next_fetch", e_fetch);

    // beq taken
    bus.Op = 6'h04; bus.Zero = 1'b1;
    step(); chk("beq_t_decode", e_decode);
    step(); chk("beq_t_branch", ov(0,0,0,0,0,0, 1,0, 10,1,1,0));
    step(); chk("beq_t_next_fetch", e_fetch);

    // beq not taken
    bus.Zero = 1'b0;
    step(); chk("beq_nt_decode", e_decode);
    step(); chk("beq_nt_branch", ov(0,0,0,0,0,0, 1,0, 10,1,0,0));
    step(); chk("beq_nt_next_fetch", e_fetch);

    // bne with Zero=1
    bus.Op = 6'h05; bus.Zero = 1'b1;
    step(); chk("bne_decode", e_decode);
    step(); chk("bne_branch", ov(0,0,0,0,0,0, 1,0, 11,1,1,0));
    step(); chk("bne_next_fetch", e_fetch);
    bus.Zero = 1'b0;

    // ori
    bus.Op = 6'h0D;
    step(); chk("ori_decode", e_decode);
    step(); chk("ori_ex", ov(0,0,0,0,0,0, 1,2, 3,0,0,0));
    step(); chk("ori_wb", ov(0,0,0,0,0,1, 0,0, 0,0,0,0));
    step(); chk("ori_next_fetch", e_fetch);

    // lui
    bus.Op = 6'h0F;
    step(); chk("lui_decode", e_decode);
    step(); chk("lui_ex", ov(0,0,0,0,0,0, 1,2, 14,0,0,0));
    step(); chk("lui_wb", ov(0,0,0,0,0,1, 0,0, 0,0,0,0));
    step(); chk("lui_next_fetch", e_fetch);

    // addi
    bus.Op = 6'h08;
    step(); chk("addi_decode", e_decode);
    step(); chk("addi_ex", ov(0,0,0,0,0,0, 1,2, 0,0,0,0));
    step(); chk("addi_wb", ov(0,0,0,0,0,1, 0,0, 0,0,0,0));
    step(); chk("addi_next_fetch", e_fetch);

    // j
    bus.Op = 6'h02;
    step(); chk("j_decode", e_decode);
    step(); chk("j_jump", ov(0,0,0,0,0,0, 0,0, 0,2,1,0));
    step(); chk("j_next_fetch", e_fetch);

    // illegal opcode
    bus.Op = 6'h3F;
    step(); chk("illop_decode", ov(0,0,0,0,0,0, 0,3, 0,0,0,1));
    step(); chk("illop_next_fetch", e_fetch);

    // unsupported funct (sra)
    bus.Op = 6'h00; bus.Funct = 6'h03;
    step(); chk("sra_decode", ov(0,0,0,0,0,0, 0,3, 0,0,0,1));
    step(); chk("sra_next_fetch", e_fetch);

`ifdef MULDIV_EN
    // div: RTYPE_EX then 4 cycles in MD_WAIT, write-back on cycle 8
    bus.Funct = 6'h1A;
    step(); chk("div_decode", e_decode);
    step(); chk("div_ex", ov(0,0,0,0,0,0, 1,0, 8,0,0,0));
    step(); chk("div_wait1", ov(0,0,0,0,0,0, 1,0, 8,0,0,0));
    step(); chk("div_wait2", ov(0,0,0,0,0,0, 1,0, 8,0,0,0));
    step(); chk("div_wait3", ov(0,0,0,0,0,0, 1,0, 8,0,0,0));
    step(); chk("div_wait4", ov(0,0,0,0,0,0, 1,0, 8,0,0,0));
    step(); chk("div_wb", ov(0,0,0,1,0,1, 0,0, 0,0,0,0));
    step(); chk("div_next_fetch", e_fetch);

    // mul aborted by reset inside MD_WAIT
    bus.Funct = 6'h18;
    step(); chk("mul_decode", e_decode);
    step(); chk("mul_ex", ov(0,0,0,0,0,0, 1,0, 9,0,0,0));
    step(); chk("mul_wait1", ov(0,0,0,0,0,0, 1,0, 9,0,0,0));
    reset = 1'b1;
    #1;
    chk("mul_reset_zero", e_zero);
    step(); chk("mul_reset_hold", e_zero);
    reset = 1'b0;
    #1;
    chk("mul_reset_fetch", e_fetch);
`else
    // mul without the option is an illegal funct
    bus.Funct = 6'h18;
    step(); chk("mul_illegal_decode", ov(0,0,0,0,0,0, 0,3, 0,0,0,1));
    step(); chk("mul_illegal_next_fetch", e_fetch);
`endif

    // lw aborted by reset in its write-back cycle
    bus.Op = 6'h23;
    step(); chk("abort_decode", e_decode);
    step(); chk("abort_memadr", ov(0,0,0,0,0,0, 1,2, 0,0,0,0));
    step(); chk("abort_memrd",  ov(1,0,0,0,0,0, 0,0, 0,0,0,0));
    step(); chk("abort_memwb",  ov(0,0,0,0,1,1, 0,0, 0,0,0,0));
    reset = 1'b1;
    #1;
    chk("abort_reset_zero", e_zero);
    step(); chk("abort_reset_hold", e_zero);
    reset = 1'b0;
    #1;
    chk("abort_fetch", e_fetch);
    step(); chk("abort_redecode", e_decode);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
